// File: rtl/avm_burst_pkg.sv
// Shared types and constants for the Avalon-MM burst copy master.
// The state enum is also what the debug state output carries.
package avm_burst_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_REQ  = 3'd1,
    RD_DATA = 3'd2,
    WR_DATA = 3'd3,
    FINISH  = 3'd4
  } state_t;

  localparam int         BYTES_PER_WORD = 4;
  localparam logic [3:0] BYTEENABLE_ALL = 4'hF;

endpackage

// File: rtl/avm_burst_copy_master_buffer.sv
// Burst staging buffer: MAX_BURST words.
// Write is clocked; read is combinational. The storage has no reset.
module avm_burst_buffer #(
  parameter int DEPTH = 8,
  parameter int DW    = 32,
  parameter int AW    = 3
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/avm_burst_copy_master.sv
// Avalon-MM burst copy master: reads up to MAX_BURST words into a local
// buffer, writes them back out at the destination, repeats until LENGTH words.
module avm_burst_copy_master
  import avm_burst_pkg::*;
#(
  parameter int AVM_DATA_WIDTH    = 32,
  parameter int AVM_ADDRESS_WIDTH = 32,
  parameter int MAX_BURST         = 8,
  parameter int BURSTCOUNT_WIDTH  = 4
) (
  input  logic                         CSI_CLOCK_CLK,
  input  logic                         CSI_CLOCK_RESET,
  input  logic                         START,
  input  logic [AVM_ADDRESS_WIDTH-1:0] SRC_ADDR,
  input  logic [AVM_ADDRESS_WIDTH-1:0] DST_ADDR,
  input  logic [AVM_DATA_WIDTH-1:0]    LENGTH,
  output logic                         DONE,
  output logic [AVM_ADDRESS_WIDTH-1:0] AVM_AVALONMASTER_ADDRESS,
  output logic                         AVM_AVALONMASTER_READ,
  output logic                         AVM_AVALONMASTER_WRITE,
  output logic [BURSTCOUNT_WIDTH-1:0]  AVM_AVALONMASTER_BURSTCOUNT,
  output logic [3:0]                   AVM_AVALONMASTER_BYTEENABLE,
  output logic [AVM_DATA_WIDTH-1:0]    AVM_AVALONMASTER_WRITEDATA,
  input  logic                         AVM_AVALONMASTER_WAITREQUEST,
  input  logic [AVM_DATA_WIDTH-1:0]    AVM_AVALONMASTER_READDATA,
  input  logic                         AVM_AVALONMASTER_READDATAVALID,
  output logic [2:0]                   o_dbg_state
);

  localparam int AW     = AVM_ADDRESS_WIDTH;
  localparam int DW     = AVM_DATA_WIDTH;
  localparam int BCW    = BURSTCOUNT_WIDTH;
  localparam int BUF_AW = $clog2(MAX_BURST);

  state_t          r_state;
  logic            r_start_d;
  logic [AW-1:0]   r_src;
  logic [AW-1:0]   r_dst;
  logic [DW-1:0]   r_remaining;
  logic [BCW-1:0]  r_burst;
  logic [BCW-1:0]  r_rcnt;
  logic [BCW-1:0]  r_wcnt;
  logic            r_read;
  logic            r_write;
  logic            r_done;
  logic [AW-1:0]   r_address;
  logic [BCW-1:0]  r_burstcount;

  logic            w_launch;
  logic            w_rd_accept;
  logic            w_capture;
  logic            w_wr_accept;
  logic            w_last_wr;
  logic [AW-1:0]   w_src_aligned;
  logic [AW-1:0]   w_dst_aligned;
  logic [AW-1:0]   w_step;
  logic [AW-1:0]   w_src_next;
  logic [AW-1:0]   w_dst_next;
  logic [DW-1:0]   w_rem_next;
  logic [BCW-1:0]  w_first_burst;
  logic [BCW-1:0]  w_next_burst;
  logic [DW-1:0]   w_buf_rdata;

  function automatic logic [BCW-1:0] burst_len(input logic [DW-1:0] rem);
    if (rem >= DW'(MAX_BURST)) return BCW'(MAX_BURST);
    return rem[BCW-1:0];
  endfunction

  // Avalon-MM handshake: a command or write beat transfers on every clock
  // edge where READ/WRITE is high and WAITREQUEST is low; until then the
  // master holds READ/WRITE, ADDRESS, BURSTCOUNT and WRITEDATA unchanged.
  // Read beats return on READDATAVALID with no back-pressure.
  assign w_launch      = START & ~r_start_d & ((r_state == IDLE) | (r_state == FINISH));
  assign w_rd_accept   = (r_state == RD_REQ) & ~AVM_AVALONMASTER_WAITREQUEST;
  assign w_capture     = AVM_AVALONMASTER_READDATAVALID & (r_rcnt < r_burst) &
                         ((r_state == RD_DATA) | w_rd_accept);
  assign w_wr_accept   = (r_state == WR_DATA) & ~AVM_AVALONMASTER_WAITREQUEST;
  assign w_last_wr     = w_wr_accept & (r_wcnt == r_burst - 1'b1);

  assign w_src_aligned = SRC_ADDR & ~AW'(BYTES_PER_WORD - 1);
  assign w_dst_aligned = DST_ADDR & ~AW'(BYTES_PER_WORD - 1);
  assign w_step        = AW'(r_burst) * AW'(BYTES_PER_WORD);
  assign w_src_next    = r_src + w_step;
  assign w_dst_next    = r_dst + w_step;
  assign w_rem_next    = r_remaining - DW'(r_burst);
  assign w_first_burst = burst_len(LENGTH);
  assign w_next_burst  = burst_len(w_rem_next);

  avm_burst_buffer #(
    .DEPTH (MAX_BURST),
    .DW    (DW),
    .AW    (BUF_AW)
  ) u_buffer (
    .i_clk   (CSI_CLOCK_CLK),
    .i_we    (w_capture),
    .i_waddr (r_rcnt[BUF_AW-1:0]),
    .i_wdata (AVM_AVALONMASTER_READDATA),
    .i_raddr (r_wcnt[BUF_AW-1:0]),
    .o_rdata (w_buf_rdata)
  );

  always_ff @(posedge CSI_CLOCK_CLK or posedge CSI_CLOCK_RESET) begin
    if (CSI_CLOCK_RESET) begin
      r_state      <= IDLE;
      r_start_d    <= 1'b0;
      r_src        <= '0;
      r_dst        <= '0;
      r_remaining  <= '0;
      r_burst      <= '0;
      r_rcnt       <= '0;
      r_wcnt       <= '0;
      r_read       <= 1'b0;
      r_write      <= 1'b0;
      r_done       <= 1'b0;
      r_address    <= '0;
      r_burstcount <= '0;
    end else begin
      r_start_d <= START;
      if (w_capture) r_rcnt <= r_rcnt + 1'b1;
      case (r_state)
        IDLE, FINISH: begin
          if (r_state == FINISH) r_done <= 1'b1;
          r_state <= IDLE;
          if (w_launch) begin
            r_src       <= w_src_aligned;
            r_dst       <= w_dst_aligned;
            r_remaining <= LENGTH;
            r_done      <= 1'b0;
            if (LENGTH != '0) begin
              r_state      <= RD_REQ;
              r_read       <= 1'b1;
              r_address    <= w_src_aligned;
              r_burst      <= w_first_burst;
              r_burstcount <= w_first_burst;
              r_rcnt       <= '0;
            end else begin
              r_state <= FINISH;
            end
          end
        end
        RD_REQ: begin
          if (!AVM_AVALONMASTER_WAITREQUEST) begin
            r_read  <= 1'b0;
            r_state <= RD_DATA;
          end
        end
        RD_DATA: begin
          // Late beats beyond the burst are dropped by w_capture's count guard.
          if (r_rcnt == r_burst) begin
            r_state   <= WR_DATA;
            r_write   <= 1'b1;
            r_address <= r_dst;
            r_wcnt    <= '0;
          end
        end
        WR_DATA: begin
          if (w_last_wr) begin
            r_write     <= 1'b0;
            r_remaining <= w_rem_next;
            r_src       <= w_src_next;
            r_dst       <= w_dst_next;
            if (w_rem_next == '0) begin
              r_state <= FINISH;
            end else begin
              r_state      <= RD_REQ;
              r_read       <= 1'b1;
              r_address    <= w_src_next;
              r_burst      <= w_next_burst;
              r_burstcount <= w_next_burst;
              r_rcnt       <= '0;
            end
          end else if (w_wr_accept) begin
            r_wcnt <= r_wcnt + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign DONE                        = r_done;
  assign AVM_AVALONMASTER_READ       = r_read;
  assign AVM_AVALONMASTER_WRITE      = r_write;
  assign AVM_AVALONMASTER_ADDRESS    = r_address;
  assign AVM_AVALONMASTER_BURSTCOUNT = r_burstcount;
  assign AVM_AVALONMASTER_BYTEENABLE = BYTEENABLE_ALL;
  assign AVM_AVALONMASTER_WRITEDATA  = r_write ? w_buf_rdata : '0;
  assign o_dbg_state                 = r_state;

endmodule

// File: tb/tb_avm_burst_copy_master.sv
// Bench for avm_burst_copy_master: an Avalon slave model plus a copy-level
// reference model feeding expected command/data queues checked by a monitor.
module tb_avm_burst_copy_master;
  import avm_burst_pkg::*;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] src;
  logic [31:0] dst;
  logic [31:0] len;
  logic        done;
  logic [31:0] avm_address;
  logic        avm_read;
  logic        avm_write;
  logic [3:0]  avm_burstcount;
  logic [3:0]  avm_byteenable;
  logic [31:0] avm_writedata;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;
  logic        avm_readdatavalid;
  logic [2:0]  dbg_state;

  int total = 0;
  int bad   = 0;

  logic [35:0] exp_rd_q[$];
  logic [35:0] exp_wr_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] dst_mem[logic [31:0]];
  logic [31:0] seed;
  bit          rand_mode = 0;
  int          wr_acc = 0;

  avm_burst_copy_master dut (
    .CSI_CLOCK_CLK                  (clk),
    .CSI_CLOCK_RESET                (rst),
    .START                          (start),
    .SRC_ADDR                       (src),
    .DST_ADDR                       (dst),
    .LENGTH                         (len),
    .DONE                           (done),
    .AVM_AVALONMASTER_ADDRESS       (avm_address),
    .AVM_AVALONMASTER_READ          (avm_read),
    .AVM_AVALONMASTER_WRITE         (avm_write),
    .AVM_AVALONMASTER_BURSTCOUNT    (avm_burstcount),
    .AVM_AVALONMASTER_BYTEENABLE    (avm_byteenable),
    .AVM_AVALONMASTER_WRITEDATA     (avm_writedata),
    .AVM_AVALONMASTER_WAITREQUEST   (avm_waitrequest),
    .AVM_AVALONMASTER_READDATA      (avm_readdata),
    .AVM_AVALONMASTER_READDATAVALID (avm_readdatavalid),
    .o_dbg_state                    (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_range(input string name, input int act, input int lo, input int hi);
    total++;
    if (act < lo || act > hi) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // Source memory contents: a fixed function of the word address.
  function automatic logic [31:0] src_word(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ seed;
  endfunction

  // Reference model: a copy of len words is a sequence of bursts of
  // min(8, words left), source and destination advancing together.
  task automatic model_copy(input logic [31:0] s_in, input logic [31:0] d_in, input logic [31:0] l);
    logic [31:0] s, d, rem;
    int b;
    s = s_in & ~32'd3;
    d = d_in & ~32'd3;
    rem = l;
    while (rem != 0) begin
      b = (rem > 32'd8) ? 8 : int'(rem);
      exp_rd_q.push_back({s, 4'(b)});
      exp_wr_q.push_back({d, 4'(b)});
      for (int i = 0; i < b; i++) exp_q.push_back(src_word(s + 32'(4 * i)));
      s   = s + 32'(4 * b);
      d   = d + 32'(4 * b);
      rem = rem - 32'(b);
    end
  endtask

  // driver tasks
  task automatic launch(input logic [31:0] s, input logic [31:0] d, input logic [31:0] l);
    model_copy(s, d, l);
    dst_mem.delete();
    @(negedge clk);
    start = 1'b0;
    src = s;
    dst = d;
    len = l;
    @(negedge clk);
    start = 1'b1;
  endtask

  task automatic wait_done(input int budget, output int cycles);
    cycles = 0;
    while (cycles < budget) begin
      @(negedge clk);
      cycles++;
      if (done) break;
    end
    if (!done) chk("done_timeout", 64'(done), 64'd1);
  endtask

  task automatic check_copy(input string tag, input logic [31:0] s_in, input logic [31:0] d_in,
                            input logic [31:0] l);
    logic [31:0] s, d, a, act;
    int errs;
    s = s_in & ~32'd3;
    d = d_in & ~32'd3;
    errs = 0;
    for (int i = 0; i < int'(l); i++) begin
      a = d + 32'(4 * i);
      act = dst_mem.exists(a) ? dst_mem[a] : ~src_word(s + 32'(4 * i));
      if (act !== src_word(s + 32'(4 * i))) errs++;
    end
    chk({tag, "_mem_errors"}, 64'(errs), 64'd0);
    chk({tag, "_mem_words"}, 64'(dst_mem.size()), 64'(l));
    chk({tag, "_rd_left"}, 64'(exp_rd_q.size()), 64'd0);
    chk({tag, "_wr_left"}, 64'(exp_wr_q.size()), 64'd0);
    chk({tag, "_data_left"}, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic clear_model();
    exp_rd_q.delete();
    exp_wr_q.delete();
    exp_q.delete();
    dst_mem.delete();
  endtask

  // Slave model and monitor: drives WAITREQUEST / read data on the falling
  // edge and checks every transfer that will happen on the next rising edge.
  logic [31:0] rd_q[$];
  int          rd_wait;
  bit          prev_rd_stall, prev_wr_stall;
  logic [31:0] prev_addr, prev_wd, cur_addr;
  logic [3:0]  prev_bc, cur_bc;
  int          wr_left, wr_idx;

  initial begin
    avm_waitrequest   = 1'b0;
    avm_readdatavalid = 1'b0;
    avm_readdata      = '0;
    rd_wait = 0; wr_left = 0; wr_idx = 0;
    prev_rd_stall = 0; prev_wr_stall = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        rd_q.delete();
        rd_wait = 0; wr_left = 0; wr_idx = 0;
        prev_rd_stall = 0; prev_wr_stall = 0;
        avm_waitrequest = 1'b0;
        avm_readdatavalid = 1'b0;
        continue;
      end
      if (prev_rd_stall) begin
        chk("rd_hold_read", 64'(avm_read), 64'd1);
        chk("rd_hold_cmd", {28'd0, avm_address, avm_burstcount}, {28'd0, prev_addr, prev_bc});
      end
      if (prev_wr_stall) begin
        chk("wr_hold_cmd", {28'd0, avm_address, avm_burstcount}, {28'd0, prev_addr, prev_bc});
        chk("wr_hold_data", 64'(avm_writedata), 64'(prev_wd));
      end
      if (wr_left > 0) chk("wr_continuous", 64'(avm_write), 64'd1);

      avm_readdatavalid = 1'b0;
      avm_readdata = $urandom;
      if (rd_q.size() > 0) begin
        if (rd_wait > 0) rd_wait--;
        else begin
          avm_readdatavalid = 1'b1;
          avm_readdata = src_word(rd_q.pop_front());
          rd_wait = rand_mode ? $urandom_range(0, 1) : 0;
        end
      end

      avm_waitrequest = rand_mode ? 1'($urandom_range(0, 1)) : 1'b0;
      prev_rd_stall = avm_read && avm_waitrequest;
      prev_wr_stall = avm_write && avm_waitrequest;
      prev_addr = avm_address;
      prev_bc   = avm_burstcount;
      prev_wd   = avm_writedata;

      if (avm_read && !avm_waitrequest) begin
        if (exp_rd_q.size() == 0) chk("unexpected_read", 64'd1, 64'd0);
        else chk("rd_cmd", {28'd0, avm_address, avm_burstcount}, {28'd0, exp_rd_q.pop_front()});
        for (int i = 0; i < int'(avm_burstcount); i++) rd_q.push_back(avm_address + 32'(4 * i));
        rd_wait = rand_mode ? $urandom_range(1, 5) - 1 : 0;
      end

      if (avm_write && !avm_waitrequest) begin
        if (wr_left == 0) begin
          if (exp_wr_q.size() == 0) chk("unexpected_write", 64'd1, 64'd0);
          else chk("wr_cmd", {28'd0, avm_address, avm_burstcount}, {28'd0, exp_wr_q.pop_front()});
          cur_addr = avm_address;
          cur_bc   = avm_burstcount;
          wr_left  = int'(avm_burstcount);
          wr_idx   = 0;
        end else begin
          chk("wr_cmd_stable", {28'd0, avm_address, avm_burstcount}, {28'd0, cur_addr, cur_bc});
        end
        if (exp_q.size() == 0) chk("unexpected_wdata", 64'd1, 64'd0);
        else chk("wr_data", 64'(avm_writedata), 64'(exp_q.pop_front()));
        dst_mem[cur_addr + 32'(4 * wr_idx)] = avm_writedata;
        wr_idx++;
        wr_acc++;
        if (wr_left > 0) wr_left--;
        if (wr_left == 0) wr_idx = 0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int n;
    logic [31:0] s, d, l;
    seed  = $urandom;
    rst   = 1'b1;
    start = 1'b0;
    src   = '0;
    dst   = '0;
    len   = '0;

    @(negedge clk);
    chk("rst_read", 64'(avm_read), 64'd0);
    chk("rst_write", 64'(avm_write), 64'd0);
    chk("rst_address", 64'(avm_address), 64'd0);
    chk("rst_burstcount", 64'(avm_burstcount), 64'd0);
    chk("rst_writedata", 64'(avm_writedata), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_state", 64'(dbg_state), 64'(IDLE));
    chk("byteenable", 64'(avm_byteenable), 64'hF);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // zero-length copy
    launch(32'h1000, 32'h2000, 32'd0);
    wait_done(10, cyc);
    chk_range("len0_done_latency", cyc, 1, 3);
    check_copy("len0", 32'h1000, 32'h2000, 32'd0);

    // single burst, zero wait states, latency check
    launch(32'h1000, 32'h2000, 32'd5);
    wait_done(200, cyc);
    chk_range("len5_done_latency", cyc, 13, 15);
    check_copy("len5", 32'h1000, 32'h2000, 32'd5);

    // multi-burst split 8/8/4
    launch(32'h1000, 32'h2000, 32'd20);
    wait_done(400, cyc);
    check_copy("len20", 32'h1000, 32'h2000, 32'd20);

    // random stalls and read latency
    rand_mode = 1;
    launch({$urandom_range(0, 32'hFFFF), 2'b00}, {$urandom_range(0, 32'hFFFF), 2'b00}, 32'd13);
    s = src; d = dst;
    wait_done(2000, cyc);
    check_copy("rand13", s, d, 32'd13);
    for (int t = 0; t < 4; t++) begin
      s = $urandom;
      d = (t == 0) ? 32'hFFFF_FFF2 : $urandom;
      l = $urandom_range(1, 24);
      launch(s, d, l);
      wait_done(3000, cyc);
      check_copy("rand_copy", s, d, l);
    end
    rand_mode = 0;

    // reset during the 3rd write beat
    n = wr_acc + 2;
    launch(32'h3000, 32'h4000, 32'd8);
    cyc = 0;
    while (wr_acc < n && cyc < 200) begin
      @(posedge clk);
      cyc++;
    end
    chk("abort_reached_beat3", 64'(wr_acc >= n), 64'd1);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("abort_read", 64'(avm_read), 64'd0);
    chk("abort_write", 64'(avm_write), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_state", 64'(dbg_state), 64'(IDLE));
    clear_model();
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    launch(32'h5000, 32'h6000, 32'd4);
    wait_done(200, cyc);
    check_copy("after_abort", 32'h5000, 32'h6000, 32'd4);

    // START held high: no relaunch, DONE sticky
    repeat (10) @(negedge clk);
    chk("hold_done_sticky", 64'(done), 64'd1);
    chk("hold_no_relaunch", 64'(dbg_state), 64'(IDLE));

    // relaunch via 1->0->1, with an ignored pulse during RD_DATA
    launch(32'h7000, 32'h8000, 32'd8);
    @(negedge clk);
    chk("relaunch_done_clear", 64'(done), 64'd0);
    cyc = 0;
    while (dbg_state != RD_DATA && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    chk("reach_rd_data", 64'(dbg_state), 64'(RD_DATA));
    start = 1'b0;
    @(negedge clk);
    start = 1'b1;
    wait_done(300, cyc);
    repeat (10) @(negedge clk);
    check_copy("pulse_ignored", 32'h7000, 32'h8000, 32'd8);
    chk("pulse_done_sticky", 64'(done), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/avm_burst_copy_master.md
Name: avm_burst_copy_master

Overview:
Avalon-MM burst master: the initiating end of the memory-mapped interface, complementing the accelerator's register slave. Software writes source address, destination address and word count into the slave registers and sets START. This block then copies the data using read bursts into a local buffer followed by write bursts, and raises DONE, which the slave reflects as status. It sits between the accelerator's register slave and the system interconnect.

Parameters:
AVM_DATA_WIDTH, 32, data bus width in bits; byte-addressed, 4 bytes per word.
AVM_ADDRESS_WIDTH, 32, byte address width.
MAX_BURST, 8, maximum beats per burst; also the local buffer depth. Power of two, 2..64.
BURSTCOUNT_WIDTH, 4, width of the burstcount port; must hold MAX_BURST, i.e. clog2(MAX_BURST)+1.

Ports:
CSI_CLOCK_CLK  in  1  clock.
CSI_CLOCK_RESET  in  1  reset; asynchronous, active-high.
START  in  1  level from the control register; a rising edge launches a copy.
SRC_ADDR  in  AVM_ADDRESS_WIDTH  source byte address; bits [1:0] are ignored.
DST_ADDR  in  AVM_ADDRESS_WIDTH  destination byte address; bits [1:0] are ignored.
LENGTH  in  AVM_DATA_WIDTH  number of 32-bit words to copy.
DONE  out  1  copy complete, sticky.
AVM_AVALONMASTER_ADDRESS  out  AVM_ADDRESS_WIDTH  burst start byte address.
AVM_AVALONMASTER_READ  out  1  read request.
AVM_AVALONMASTER_WRITE  out  1  write request.
AVM_AVALONMASTER_BURSTCOUNT  out  BURSTCOUNT_WIDTH  beats in the current burst.
AVM_AVALONMASTER_BYTEENABLE  out  4  constant 4'hF.
AVM_AVALONMASTER_WRITEDATA  out  AVM_DATA_WIDTH  write beat data.
AVM_AVALONMASTER_WAITREQUEST  in  1  slave stall.
AVM_AVALONMASTER_READDATA  in  AVM_DATA_WIDTH  read beat data.
AVM_AVALONMASTER_READDATAVALID  in  1  read beat valid.

Behaviour:
- Reset values: READ=0, WRITE=0, ADDRESS=0, BURSTCOUNT=0, WRITEDATA=0, DONE=0; FSM in IDLE; edge detector cleared.
- START is registered once. A launch requires START=1 in the current cycle and 0 in the previous cycle.
- Launch action: latch SRC/DST with bits [1:0] forced to 0, set remaining=LENGTH, clear DONE.
- START edges that occur while not in IDLE/FINISH are ignored.
- FSM states: IDLE, RD_REQ, RD_DATA, WR_DATA, FINISH.
- IDLE: on launch, go to RD_REQ if LENGTH != 0. If LENGTH == 0, go straight to FINISH.
- RD_REQ:
  - burst = min(MAX_BURST, remaining), computed on state entry.
  - Drive READ=1, ADDRESS=src, BURSTCOUNT=burst.
  - Hold READ, ADDRESS and BURSTCOUNT stable while WAITREQUEST=1.
  - The first cycle with WAITREQUEST=0 accepts the command: READ drops the next cycle and the FSM goes to RD_DATA.
- RD_DATA:
  - Each READDATAVALID=1 writes READDATA into buffer[rcnt] and increments rcnt.
  - A READDATAVALID in the cycle the command is accepted is also captured.
  - When rcnt==burst, go to WR_DATA with wcnt=0.
  - Extra READDATAVALID beats beyond burst are dropped.
- WR_DATA:
  - Drive WRITE=1, ADDRESS=dst, BURSTCOUNT=burst, WRITEDATA=buffer[wcnt].
  - ADDRESS and BURSTCOUNT stay constant for the entire burst.
  - A beat is consumed in each cycle with WAITREQUEST=0; wcnt then increments.
  - While stalled, all outputs are held. WRITE stays asserted continuously between beats, with no idle cycles.
  - After the last beat is accepted: remaining -= burst, src += burst*4, dst += burst*4.
  - Then go to FINISH if remaining == 0, else RD_REQ.
- FINISH: DONE=1, go to IDLE. DONE stays 1 until the next launch.
- Address arithmetic wraps modulo 2^AVM_ADDRESS_WIDTH with no error flag.
- The remaining counter is AVM_DATA_WIDTH wide; no overflow is possible.
- Reset mid-operation: abort immediately, all outputs go to reset values, the partial copy is abandoned, DONE=0.
- Latency for a single burst of N beats with zero wait states and a 1-cycle read latency: DONE rises 2N+4 cycles after the START edge (±1 is a verification tolerance only).

Decomposition:
- Shared package avm_burst_pkg holds:
  - the state enum type (IDLE, RD_REQ, RD_DATA, WR_DATA, FINISH);
  - BYTES_PER_WORD=4;
  - BYTEENABLE_ALL=4'hF.
- One sub-module, avm_burst_buffer:
  - MAX_BURST x AVM_DATA_WIDTH register file;
  - one synchronous write port and one asynchronous read port;
  - no reset on the storage.

Test Plan:
- LENGTH=0, START 0->1 -> DONE=1 within 3 cycles; READ and WRITE never asserted.
- SRC=0x1000, DST=0x2000, LENGTH=5, zero wait states -> one read burst (ADDRESS 0x1000, BURSTCOUNT 5), then one write burst (ADDRESS 0x2000, BURSTCOUNT 5) carrying the 5 read words in order; then DONE=1.
- LENGTH=20, MAX_BURST=8 -> read bursts at 0x1000/0x1020/0x1040 with counts 8/8/4; write bursts at 0x2000/0x2020/0x2040 with counts 8/8/4; destination model equals source model.
- Random WAITREQUEST (50%) and random 1-5 cycle read latency, LENGTH=13 -> ADDRESS, BURSTCOUNT and WRITEDATA stable during stalls; no beat lost or duplicated; memory compare passes.
- Reset asserted during the 3rd write beat -> next edge: READ=WRITE=0, DONE=0, state IDLE; a new START edge completes a full LENGTH=4 copy.
- START held at 1 after DONE -> no relaunch. START 1->0->1 -> DONE clears on the launch and a second copy runs; a START pulse during RD_DATA is ignored.
